// File: rtl/ej4_decim_fifo_if.sv
// Sample-in / handshake-out bundle of the decimating FIFO.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface ej4_decim_fifo_if #(
  parameter int NB_DATA    = 8,
  parameter int NB_DECIM   = 4,
  parameter int LOG2_DEPTH = 3
);
  logic [NB_DATA-1:0]  i_y;
  logic                i_y_valid;
  logic [NB_DECIM-1:0] i_decim;
  logic                i_clear;
  logic [NB_DATA-1:0]  o_data;
  logic                o_valid;
  logic                i_ready;
  logic [LOG2_DEPTH:0] o_level;
  logic                o_overflow;

  modport slave (
    input  i_y, i_y_valid, i_decim, i_clear, i_ready,
    output o_data, o_valid, o_level, o_overflow
  );

  modport master (
    output i_y, i_y_valid, i_decim, i_clear, i_ready,
    input  o_data, o_valid, o_level, o_overflow
  );
endinterface

// File: rtl/ej4_decim_fifo.sv
// Decimator plus circular FIFO behind the IIR filter.
// Keeps one of every i_decim+1 valid samples and hands them to a slower consumer.

module ej4_decim_fifo_cell #(
  parameter int NB_DATA = 8
) (
  input  logic               clock,
  input  logic               i_rst_n,
  input  logic               i_we,
  input  logic [NB_DATA-1:0] i_d,
  output logic [NB_DATA-1:0] o_q
);
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n)  o_q <= '0;
    else if (i_we) o_q <= i_d;
  end
endmodule

module ej4_decim_fifo #(
  parameter int NB_DATA    = 8,
  parameter int NB_DECIM   = 4,
  parameter int LOG2_DEPTH = 3
) (
  input  logic               clock,
  input  logic               i_rst_n,
  ej4_decim_fifo_if.slave    bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FULL_LVL = (LOG2_DEPTH+1)'(DEPTH);

  logic [NB_DECIM-1:0]               phase, phase_nxt;
  logic [LOG2_DEPTH-1:0]             wr_ptr, rd_ptr;
  logic [LOG2_DEPTH:0]               level;
  logic                              overflow;
  logic                              keep, full, pop, push, drop;
  logic [DEPTH-1:0]                  cell_we;
  logic [DEPTH-1:0][NB_DATA-1:0]     cell_q;

  // Phase wraps on >= so a live decrease of i_decim below the phase recovers in one sample.
  always_comb begin
    phase_nxt = (phase >= bus.i_decim) ? '0 : phase + 1'b1;
    keep      = bus.i_y_valid && (phase == '0);
    full      = (level == FULL_LVL);
    pop       = (level != '0) && bus.i_ready;
    push      = keep && (!full || pop);
    drop      = keep && full && !pop;
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (bus.i_clear) begin
      phase    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.i_y_valid) phase  <= phase_nxt;
      if (push)          wr_ptr <= wr_ptr + 1'b1;
      if (pop)           rd_ptr <= rd_ptr + 1'b1;
      if (drop)          overflow <= 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // When full with a pop, wr_ptr == rd_ptr: the head is read this cycle and overwritten at the edge.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    assign cell_we[g] = push && !bus.i_clear && (wr_ptr == LOG2_DEPTH'(g));
    ej4_decim_fifo_cell #(.NB_DATA(NB_DATA)) u_cell (
      .clock   (clock),
      .i_rst_n (i_rst_n),
      .i_we    (cell_we[g]),
      .i_d     (bus.i_y),
      .o_q     (cell_q[g])
    );
  end

  assign bus.o_data     = cell_q[rd_ptr];
  assign bus.o_valid    = (level != '0);
  assign bus.o_level    = level;
  assign bus.o_overflow = overflow;
endmodule

// File: tb/tb_ej4_decim_fifo.sv
// Bench for ej4_decim_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a long randomized run.
module tb_ej4_decim_fifo;
  localparam int NB_DATA = 8, NB_DECIM = 4, LOG2_DEPTH = 3, DEPTH = 8;

  logic clock = 1'b0;
  logic i_rst_n;
  ej4_decim_fifo_if #(.NB_DATA(NB_DATA), .NB_DECIM(NB_DECIM), .LOG2_DEPTH(LOG2_DEPTH)) bus ();
  ej4_decim_fifo #(.NB_DATA(NB_DATA), .NB_DECIM(NB_DECIM), .LOG2_DEPTH(LOG2_DEPTH)) dut (
    .clock   (clock),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored samples plus a decimation phase.
  logic [7:0] mq[$];
  int         m_phase = 0;
  bit         m_ovf = 0;
  always @(posedge clock or negedge i_rst_n) begin : mdl
    bit pop, keep;
    if (!i_rst_n) begin
      mq.delete(); m_phase = 0; m_ovf = 0;
    end else if (bus.i_clear) begin
      mq.delete(); m_phase = 0; m_ovf = 0;
    end else begin
      pop  = (mq.size() != 0) && bus.i_ready;
      keep = bus.i_y_valid && (m_phase == 0);
      if (bus.i_y_valid) m_phase = (m_phase >= int'(bus.i_decim)) ? 0 : m_phase + 1;
      if (pop) void'(mq.pop_front());
      if (keep) begin
        if (mq.size() < DEPTH) mq.push_back(bus.i_y);
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle compare plus a log of every sample the consumer accepts.
  logic [7:0] seen[$];
  logic [7:0] exp_q[$];
  int max_level = 0;
  always @(negedge clock) begin
    chk("level", 32'(bus.o_level), 32'(mq.size()));
    chk("valid", 32'(bus.o_valid), 32'(mq.size() != 0));
    chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
    if (mq.size() != 0) chk("data", 32'(bus.o_data), 32'(mq[0]));
    else if (!i_rst_n)  chk("rst_data", 32'(bus.o_data), 32'h0);
    if (int'(bus.o_level) > max_level) max_level = int'(bus.o_level);
    if (i_rst_n && bus.o_valid && bus.i_ready && !bus.i_clear) seen.push_back(bus.o_data);
  end

  // One clock of stimulus; returns 1 ns after the edge that consumed it.
  task automatic cyc(logic [7:0] y, bit yv, int decim, bit clr, bit rdy);
    bus.i_y = y; bus.i_y_valid = yv; bus.i_decim = NB_DECIM'(decim);
    bus.i_clear = clr; bus.i_ready = rdy;
    @(posedge clock); #1;
  endtask

  task automatic check_seen(string name);
    chk({name, "_count"}, 32'(seen.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk(name, (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  task automatic check_zero(string name);
    chk({name, "_level"}, 32'(bus.o_level), 32'h0);
    chk({name, "_valid"}, 32'(bus.o_valid), 32'h0);
    chk({name, "_ovf"},   32'(bus.o_overflow), 32'h0);
    chk({name, "_data"},  32'(bus.o_data), 32'h0);
  endtask

  initial begin
    logic [7:0] pt[7];
    pt = '{8'd1, 8'd1, 8'd2, 8'd5, 8'd4, 8'd11, 8'hFD};
    i_rst_n = 1'b0;
    bus.i_y = '0; bus.i_y_valid = 0; bus.i_decim = '0; bus.i_clear = 0; bus.i_ready = 0;
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) cyc(8'($urandom), 1, 0, 0, 1);
    check_zero("reset");
    i_rst_n = 1'b1;

    // Pass-through with one-cycle latency.
    cyc(0, 0, 0, 1, 1);
    seen.delete(); max_level = 0;
    foreach (pt[i]) begin
      cyc(pt[i], 1, 0, 0, 1);
      chk("pt_data", 32'(bus.o_data), 32'(pt[i]));
      chk("pt_valid", 32'(bus.o_valid), 32'h1);
    end
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    exp_q = '{8'd1, 8'd1, 8'd2, 8'd5, 8'd4, 8'd11, 8'hFD};
    check_seen("pt_seq");
    chk("pt_maxlvl", 32'(max_level), 32'h1);

    // Decimate by 3.
    cyc(0, 0, 2, 1, 1);
    seen.delete();
    for (int v = 1; v <= 9; v++) cyc(8'(v), 1, 2, 0, 1);
    cyc(0, 0, 2, 0, 1); cyc(0, 0, 2, 0, 1);
    exp_q = '{8'd1, 8'd4, 8'd7};
    check_seen("dec");

    // Lower i_decim while phase is 2: next sample wraps, then every sample kept.
    cyc(0, 0, 2, 1, 1);
    seen.delete();
    cyc(8'd21, 1, 2, 0, 1); cyc(8'd22, 1, 2, 0, 1);
    cyc(8'd23, 1, 0, 0, 1); cyc(8'd24, 1, 0, 0, 1); cyc(8'd25, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    exp_q = '{8'd21, 8'd24, 8'd25};
    check_seen("dec_live");

    // Fill and overflow, then drain.
    cyc(0, 0, 0, 1, 0);
    seen.delete();
    for (int v = 1; v <= 8; v++) cyc(8'(v), 1, 0, 0, 0);
    chk("fill_level", 32'(bus.o_level), 32'd8);
    chk("fill_ovf", 32'(bus.o_overflow), 32'h0);
    cyc(8'd9, 1, 0, 0, 0);
    chk("ovf_set", 32'(bus.o_overflow), 32'h1);
    chk("ovf_level", 32'(bus.o_level), 32'd8);
    cyc(8'd10, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    check_seen("drain");
    chk("drain_level", 32'(bus.o_level), 32'h0);
    chk("drain_ovf", 32'(bus.o_overflow), 32'h1);

    // Full with simultaneous push and pop across pointer wrap.
    cyc(0, 0, 0, 1, 0);
    seen.delete();
    for (int v = 1; v <= 8; v++) cyc(8'(v), 1, 0, 0, 0);
    for (int v = 9; v <= 20; v++) begin
      cyc(8'(v), 1, 0, 0, 1);
      chk("fullpp_level", 32'(bus.o_level), 32'd8);
      chk("fullpp_ovf", 32'(bus.o_overflow), 32'h0);
    end
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    exp_q.delete();
    for (int v = 1; v <= 20; v++) exp_q.push_back(8'(v));
    check_seen("fullpp_seq");

    // Clear beats a same-cycle push and pop.
    cyc(0, 0, 0, 1, 0);
    for (int v = 1; v <= 9; v++) cyc(8'(v), 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    chk("pre_clr_level", 32'(bus.o_level), 32'd5);
    chk("pre_clr_ovf", 32'(bus.o_overflow), 32'h1);
    cyc(8'h77, 1, 0, 1, 1);
    chk("clr_level", 32'(bus.o_level), 32'h0);
    chk("clr_valid", 32'(bus.o_valid), 32'h0);
    chk("clr_ovf", 32'(bus.o_overflow), 32'h0);
    cyc(8'h5A, 1, 0, 0, 0);
    chk("post_clr_valid", 32'(bus.o_valid), 32'h1);
    chk("post_clr_data", 32'(bus.o_data), 32'h5A);
    chk("post_clr_level", 32'(bus.o_level), 32'h1);

    // Randomized run with an asynchronous reset dropped mid-stream.
    begin
      int decim = 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 49) == 0) decim = $urandom_range(0, 3);
        cyc(8'($urandom), $urandom_range(0, 3) != 0, decim,
            $urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0);
        if (i == 1500) begin
          #2 i_rst_n = 1'b0;
          #1 check_zero("async_rst");
          for (int k = 0; k < 3; k++) cyc(8'($urandom), 1, decim, 0, 1);
          i_rst_n = 1'b1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
